// File: rtl/ibex_ctrl_pkg.sv
// Shared encodings for the ID-stage controller: FSM states, PC/exception mux selects and cause codes.
// Pure declarations: no latency and no handshake.
package ibex_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET, BOOT_SET, WAIT_SLEEP, SLEEP, FIRST_FETCH,
    DECODE, FLUSH, IRQ_TAKEN, DBG_TAKEN_IF, DBG_TAKEN_ID
  } ctrl_fsm_e;

  typedef enum logic [2:0] {
    PC_BOOT = 3'd0,
    PC_JUMP = 3'd1,
    PC_EXC  = 3'd2,
    PC_ERET = 3'd3,
    PC_DRET = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    EXC_PC_EXC     = 2'd0,
    EXC_PC_IRQ     = 2'd1,
    EXC_PC_DBD     = 2'd2,
    EXC_PC_DBG_EXC = 2'd3
  } exc_pc_sel_e;

  // Interrupt causes carry bit 5 set; synchronous exceptions do not.
  typedef enum logic [5:0] {
    EXC_CAUSE_INSN_ADDR_FAULT  = 6'h01,
    EXC_CAUSE_ILLEGAL_INSN     = 6'h02,
    EXC_CAUSE_BREAKPOINT       = 6'h03,
    EXC_CAUSE_LOAD_ACCESS      = 6'h05,
    EXC_CAUSE_STORE_ACCESS     = 6'h07,
    EXC_CAUSE_ECALL_UMODE      = 6'h08,
    EXC_CAUSE_ECALL_MMODE      = 6'h0B,
    EXC_CAUSE_IRQ_SOFTWARE_M   = 6'h23,
    EXC_CAUSE_IRQ_TIMER_M      = 6'h27,
    EXC_CAUSE_IRQ_EXTERNAL_M   = 6'h2B,
    EXC_CAUSE_IRQ_NM           = 6'h3F
  } exc_cause_e;

  typedef enum logic [2:0] {
    DBG_CAUSE_NONE    = 3'd0,
    DBG_CAUSE_EBREAK  = 3'd1,
    DBG_CAUSE_HALTREQ = 3'd3,
    DBG_CAUSE_STEP    = 3'd4
  } dbg_cause_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

endpackage

// File: rtl/ibex_ctrl_irq_prio.sv
// Interrupt cause encoder: NMI > lowest fast IRQ > external > software > timer.
// Purely combinational, zero latency, no backpressure.
module ibex_ctrl_irq_prio
  import ibex_ctrl_pkg::*;
(
  input  logic        i_nmi,
  input  logic [14:0] i_mfip,
  input  logic        i_meip,
  input  logic        i_msip,
  input  logic        i_mtip,
  output logic [5:0]  o_cause
);

  // Assignments run lowest priority first so the last matching source wins.
  always_comb begin
    o_cause = EXC_CAUSE_IRQ_TIMER_M;
    if (i_mtip) o_cause = EXC_CAUSE_IRQ_TIMER_M;
    if (i_msip) o_cause = EXC_CAUSE_IRQ_SOFTWARE_M;
    if (i_meip) o_cause = EXC_CAUSE_IRQ_EXTERNAL_M;
    for (int i = 14; i >= 0; i--) begin
      if (i_mfip[i]) o_cause = {2'b11, i[3:0]};
    end
    if (i_nmi) o_cause = EXC_CAUSE_IRQ_NM;
  end

endmodule

// File: rtl/ibex_core_controller.sv
// ID-stage control FSM: boot, fetch, sleep, exceptions, interrupts and debug entry/exit.
// Selects/strobes are combinational from state; mode flags and ctrl_busy_o register on the next edge; stalls hold ID.
module ibex_core_controller
  import ibex_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  output logic        ctrl_busy_o,
  input  logic        illegal_insn_i,
  input  logic        ecall_insn_i,
  input  logic        mret_insn_i,
  input  logic        dret_insn_i,
  input  logic        wfi_insn_i,
  input  logic        ebrk_insn_i,
  input  logic        csr_pipe_flush_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [15:0] instr_compressed_i,
  input  logic        instr_is_compressed_i,
  input  logic        instr_fetch_err_i,
  input  logic [31:0] pc_id_i,
  output logic        instr_valid_clear_o,
  output logic        id_in_ready_o,
  output logic        instr_req_o,
  output logic        pc_set_o,
  output logic [2:0]  pc_mux_o,
  output logic [1:0]  exc_pc_mux_o,
  output logic [5:0]  exc_cause_o,
  input  logic [31:0] lsu_addr_last_i,
  input  logic        load_err_i,
  input  logic        store_err_i,
  input  logic        branch_set_i,
  input  logic        jump_set_i,
  output logic [31:0] csr_mtval_o,
  input  logic        csr_mstatus_mie_i,
  input  logic        csr_mstatus_tw_i,
  input  logic        irq_pending_i,
  input  logic        irq_nm_i,
  input  logic        csr_msip_i,
  input  logic        csr_mtip_i,
  input  logic        csr_meip_i,
  input  logic [14:0] csr_mfip_i,
  input  logic        debug_req_i,
  input  logic        debug_single_step_i,
  input  logic        debug_ebreakm_i,
  input  logic        debug_ebreaku_i,
  input  logic [1:0]  priv_mode_i,
  output logic        debug_mode_o,
  output logic [2:0]  debug_cause_o,
  output logic        debug_csr_save_o,
  output logic        csr_save_if_o,
  output logic        csr_save_id_o,
  output logic        csr_save_cause_o,
  output logic        csr_restore_mret_id_o,
  output logic        csr_restore_dret_id_o,
  input  logic        stall_lsu_i,
  input  logic        stall_multdiv_i,
  input  logic        stall_jump_i,
  input  logic        stall_branch_i,
  output logic        perf_jump_o,
  output logic        perf_tbranch_o
);

  ctrl_fsm_e r_state, w_next;
  logic r_debug_mode, r_nmi_mode, r_step_pending, r_ctrl_busy;
  logic w_debug_mode_d, w_nmi_mode_d, w_step_pending_d;
  logic w_halt_if, w_retain_id, w_flush_id, w_exc;
  logic w_stall, w_illegal, w_exc_req, w_special_req, w_handle_irq, w_enter_debug, w_ebreak_into_debug;
  logic [5:0] w_irq_cause;

  assign w_stall   = stall_lsu_i | stall_multdiv_i | stall_jump_i | stall_branch_i;
  assign w_illegal = illegal_insn_i | (dret_insn_i & ~r_debug_mode) |
                     ((priv_mode_i == PRIV_LVL_U) & (mret_insn_i | (wfi_insn_i & csr_mstatus_tw_i)));
  assign w_exc_req = instr_valid_i & (ecall_insn_i | ebrk_insn_i | w_illegal | instr_fetch_err_i);
  assign w_special_req = mret_insn_i | dret_insn_i | wfi_insn_i | csr_pipe_flush_i |
                         w_exc_req | load_err_i | store_err_i;
  assign w_handle_irq  = ~r_debug_mode & ~r_nmi_mode & (irq_nm_i | (irq_pending_i & csr_mstatus_mie_i));
  assign w_enter_debug = (debug_req_i | r_step_pending) & ~r_debug_mode;
  assign w_ebreak_into_debug = (priv_mode_i == PRIV_LVL_M) ? debug_ebreakm_i :
                               (priv_mode_i == PRIV_LVL_U) ? debug_ebreaku_i : 1'b0;

  ibex_ctrl_irq_prio u_irq_prio (
    .i_nmi   (irq_nm_i),
    .i_mfip  (csr_mfip_i),
    .i_meip  (csr_meip_i),
    .i_msip  (csr_msip_i),
    .i_mtip  (csr_mtip_i),
    .o_cause (w_irq_cause)
  );

  always_comb begin
    w_next = r_state;
    w_debug_mode_d = r_debug_mode;
    w_nmi_mode_d = r_nmi_mode;
    w_step_pending_d = r_step_pending;
    w_halt_if = 1'b0;
    w_retain_id = 1'b0;
    w_flush_id = 1'b0;
    w_exc = 1'b0;
    instr_req_o = 1'b1;
    pc_set_o = 1'b0;
    pc_mux_o = PC_BOOT;
    exc_pc_mux_o = EXC_PC_EXC;
    exc_cause_o = '0;
    csr_mtval_o = '0;
    debug_cause_o = DBG_CAUSE_NONE;
    debug_csr_save_o = 1'b0;
    csr_save_if_o = 1'b0;
    csr_save_id_o = 1'b0;
    csr_save_cause_o = 1'b0;
    csr_restore_mret_id_o = 1'b0;
    csr_restore_dret_id_o = 1'b0;
    perf_jump_o = 1'b0;
    perf_tbranch_o = 1'b0;
    case (r_state)
      RESET: begin
        instr_req_o = 1'b0;
        w_halt_if = 1'b1;
        w_retain_id = 1'b1;
        if (fetch_enable_i) w_next = BOOT_SET;
      end
      BOOT_SET: begin
        w_halt_if = 1'b1;
        pc_set_o = 1'b1;
        pc_mux_o = PC_BOOT;
        w_next = FIRST_FETCH;
      end
      FIRST_FETCH: begin
        if (w_handle_irq) w_next = IRQ_TAKEN;
        else if (w_enter_debug) w_next = DBG_TAKEN_IF;
        else if (id_in_ready_o) w_next = DECODE;
      end
      DECODE: begin
        if (instr_valid_i & w_special_req) begin
          w_halt_if = 1'b1;
          w_retain_id = 1'b1;
          w_next = FLUSH;
        end else begin
          if (branch_set_i | jump_set_i) begin
            pc_set_o = 1'b1;
            pc_mux_o = PC_JUMP;
            perf_tbranch_o = branch_set_i;
            perf_jump_o = jump_set_i;
          end
          if (instr_valid_i & ~w_stall & debug_single_step_i & ~r_debug_mode)
            w_step_pending_d = 1'b1;
          if (~w_stall & w_enter_debug) begin
            w_halt_if = 1'b1;
            w_next = DBG_TAKEN_IF;
          end else if (~w_stall & w_handle_irq) begin
            w_halt_if = 1'b1;
            w_next = IRQ_TAKEN;
          end
        end
      end
      IRQ_TAKEN: begin
        pc_set_o = 1'b1;
        pc_mux_o = PC_EXC;
        exc_pc_mux_o = EXC_PC_IRQ;
        csr_save_if_o = 1'b1;
        csr_save_cause_o = 1'b1;
        exc_cause_o = w_irq_cause;
        if (irq_nm_i) w_nmi_mode_d = 1'b1;
        w_next = DECODE;
      end
      DBG_TAKEN_IF: begin
        pc_set_o = 1'b1;
        pc_mux_o = PC_EXC;
        exc_pc_mux_o = EXC_PC_DBD;
        csr_save_if_o = 1'b1;
        debug_csr_save_o = 1'b1;
        debug_cause_o = r_step_pending ? DBG_CAUSE_STEP : DBG_CAUSE_HALTREQ;
        w_debug_mode_d = 1'b1;
        w_step_pending_d = 1'b0;
        w_next = DECODE;
      end
      DBG_TAKEN_ID: begin
        w_flush_id = 1'b1;
        pc_set_o = 1'b1;
        pc_mux_o = PC_EXC;
        exc_pc_mux_o = EXC_PC_DBD;
        csr_save_id_o = 1'b1;
        debug_csr_save_o = 1'b1;
        debug_cause_o = DBG_CAUSE_EBREAK;
        w_debug_mode_d = 1'b1;
        w_next = DECODE;
      end
      FLUSH: begin
        w_halt_if = 1'b1;
        w_flush_id = 1'b1;
        w_next = DECODE;
        if (instr_valid_i & instr_fetch_err_i) begin
          w_exc = 1'b1;
          exc_cause_o = EXC_CAUSE_INSN_ADDR_FAULT;
          csr_mtval_o = pc_id_i;
        end else if (instr_valid_i & w_illegal) begin
          w_exc = 1'b1;
          exc_cause_o = EXC_CAUSE_ILLEGAL_INSN;
          csr_mtval_o = instr_is_compressed_i ? {16'b0, instr_compressed_i} : instr_i;
        end else if (instr_valid_i & ecall_insn_i) begin
          w_exc = 1'b1;
          exc_cause_o = (priv_mode_i == PRIV_LVL_M) ? EXC_CAUSE_ECALL_MMODE : EXC_CAUSE_ECALL_UMODE;
        end else if (instr_valid_i & ebrk_insn_i) begin
          // Debug entry via ebreak must not disturb the M-mode trap CSRs.
          if (r_debug_mode) begin
            pc_set_o = 1'b1;
            pc_mux_o = PC_EXC;
            exc_pc_mux_o = EXC_PC_DBD;
          end else if (w_ebreak_into_debug) begin
            w_next = DBG_TAKEN_ID;
          end else begin
            w_exc = 1'b1;
            exc_cause_o = EXC_CAUSE_BREAKPOINT;
          end
        end else if (load_err_i) begin
          w_exc = 1'b1;
          exc_cause_o = EXC_CAUSE_LOAD_ACCESS;
          csr_mtval_o = lsu_addr_last_i;
        end else if (store_err_i) begin
          w_exc = 1'b1;
          exc_cause_o = EXC_CAUSE_STORE_ACCESS;
          csr_mtval_o = lsu_addr_last_i;
        end else begin
          if (instr_valid_i & mret_insn_i) begin
            pc_set_o = 1'b1;
            pc_mux_o = PC_ERET;
            csr_restore_mret_id_o = 1'b1;
            w_nmi_mode_d = 1'b0;
          end else if (instr_valid_i & dret_insn_i) begin
            pc_set_o = 1'b1;
            pc_mux_o = PC_DRET;
            csr_restore_dret_id_o = 1'b1;
            w_debug_mode_d = 1'b0;
          end else if (instr_valid_i & wfi_insn_i & ~r_debug_mode & ~debug_single_step_i) begin
            w_next = WAIT_SLEEP;
          end
          if (w_enter_debug) w_next = DBG_TAKEN_IF;
        end
        if (w_exc) begin
          pc_set_o = 1'b1;
          pc_mux_o = PC_EXC;
          exc_pc_mux_o = r_debug_mode ? EXC_PC_DBG_EXC : EXC_PC_EXC;
          csr_save_id_o = 1'b1;
          csr_save_cause_o = 1'b1;
        end
      end
      WAIT_SLEEP: begin
        instr_req_o = 1'b0;
        w_halt_if = 1'b1;
        w_flush_id = 1'b1;
        w_next = SLEEP;
      end
      SLEEP: begin
        instr_req_o = 1'b0;
        w_halt_if = 1'b1;
        if (irq_pending_i | irq_nm_i | debug_req_i) w_next = FIRST_FETCH;
      end
      default: w_next = RESET;
    endcase
  end

  assign id_in_ready_o       = ~w_stall & ~w_halt_if;
  assign instr_valid_clear_o = ~(w_stall | w_retain_id) | w_flush_id;
  assign debug_mode_o        = r_debug_mode;
  assign ctrl_busy_o         = r_ctrl_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= RESET;
      r_debug_mode   <= 1'b0;
      r_nmi_mode     <= 1'b0;
      r_step_pending <= 1'b0;
      r_ctrl_busy    <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_debug_mode   <= w_debug_mode_d;
      r_nmi_mode     <= w_nmi_mode_d;
      r_step_pending <= w_step_pending_d;
      r_ctrl_busy    <= (w_next != SLEEP) && (w_next != RESET);
    end
  end

endmodule

// File: tb/tb_ibex_core_controller.sv
// Directed bench for the ID-stage controller: boot, exceptions, IRQs, NMI, debug, WFI and reset.
// Inputs change and outputs are sampled just after the falling edge.
module tb_ibex_core_controller;

  logic clk_i, rst_i, fetch_enable_i, ctrl_busy_o;
  logic illegal_insn_i, ecall_insn_i, mret_insn_i, dret_insn_i, wfi_insn_i, ebrk_insn_i, csr_pipe_flush_i;
  logic instr_valid_i, instr_is_compressed_i, instr_fetch_err_i;
  logic [31:0] instr_i, pc_id_i, lsu_addr_last_i, csr_mtval_o;
  logic [15:0] instr_compressed_i;
  logic instr_valid_clear_o, id_in_ready_o, instr_req_o, pc_set_o;
  logic [2:0] pc_mux_o, debug_cause_o;
  logic [1:0] exc_pc_mux_o, priv_mode_i;
  logic [5:0] exc_cause_o;
  logic load_err_i, store_err_i, branch_set_i, jump_set_i;
  logic csr_mstatus_mie_i, csr_mstatus_tw_i, irq_pending_i, irq_nm_i, csr_msip_i, csr_mtip_i, csr_meip_i;
  logic [14:0] csr_mfip_i;
  logic debug_req_i, debug_single_step_i, debug_ebreakm_i, debug_ebreaku_i;
  logic debug_mode_o, debug_csr_save_o, csr_save_if_o, csr_save_id_o, csr_save_cause_o;
  logic csr_restore_mret_id_o, csr_restore_dret_id_o;
  logic stall_lsu_i, stall_multdiv_i, stall_jump_i, stall_branch_i, perf_jump_o, perf_tbranch_o;

  int checks = 0;
  int errors = 0;

  ibex_core_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_enable_i(fetch_enable_i), .ctrl_busy_o(ctrl_busy_o),
    .illegal_insn_i(illegal_insn_i), .ecall_insn_i(ecall_insn_i), .mret_insn_i(mret_insn_i),
    .dret_insn_i(dret_insn_i), .wfi_insn_i(wfi_insn_i), .ebrk_insn_i(ebrk_insn_i),
    .csr_pipe_flush_i(csr_pipe_flush_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_compressed_i(instr_compressed_i), .instr_is_compressed_i(instr_is_compressed_i),
    .instr_fetch_err_i(instr_fetch_err_i), .pc_id_i(pc_id_i),
    .instr_valid_clear_o(instr_valid_clear_o), .id_in_ready_o(id_in_ready_o),
    .instr_req_o(instr_req_o), .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o),
    .exc_pc_mux_o(exc_pc_mux_o), .exc_cause_o(exc_cause_o), .lsu_addr_last_i(lsu_addr_last_i),
    .load_err_i(load_err_i), .store_err_i(store_err_i), .branch_set_i(branch_set_i),
    .jump_set_i(jump_set_i), .csr_mtval_o(csr_mtval_o), .csr_mstatus_mie_i(csr_mstatus_mie_i),
    .csr_mstatus_tw_i(csr_mstatus_tw_i), .irq_pending_i(irq_pending_i), .irq_nm_i(irq_nm_i),
    .csr_msip_i(csr_msip_i), .csr_mtip_i(csr_mtip_i), .csr_meip_i(csr_meip_i),
    .csr_mfip_i(csr_mfip_i), .debug_req_i(debug_req_i), .debug_single_step_i(debug_single_step_i),
    .debug_ebreakm_i(debug_ebreakm_i), .debug_ebreaku_i(debug_ebreaku_i),
    .priv_mode_i(priv_mode_i), .debug_mode_o(debug_mode_o), .debug_cause_o(debug_cause_o),
    .debug_csr_save_o(debug_csr_save_o), .csr_save_if_o(csr_save_if_o),
    .csr_save_id_o(csr_save_id_o), .csr_save_cause_o(csr_save_cause_o),
    .csr_restore_mret_id_o(csr_restore_mret_id_o), .csr_restore_dret_id_o(csr_restore_dret_id_o),
    .stall_lsu_i(stall_lsu_i), .stall_multdiv_i(stall_multdiv_i), .stall_jump_i(stall_jump_i),
    .stall_branch_i(stall_branch_i), .perf_jump_o(perf_jump_o), .perf_tbranch_o(perf_tbranch_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1; fetch_enable_i = 0;
    illegal_insn_i = 0; ecall_insn_i = 0; mret_insn_i = 0; dret_insn_i = 0;
    wfi_insn_i = 0; ebrk_insn_i = 0; csr_pipe_flush_i = 0;
    instr_valid_i = 0; instr_i = 0; instr_compressed_i = 0; instr_is_compressed_i = 0;
    instr_fetch_err_i = 0; pc_id_i = 32'h0000_0100; lsu_addr_last_i = 0;
    load_err_i = 0; store_err_i = 0; branch_set_i = 0; jump_set_i = 0;
    csr_mstatus_mie_i = 0; csr_mstatus_tw_i = 0; irq_pending_i = 0; irq_nm_i = 0;
    csr_msip_i = 0; csr_mtip_i = 0; csr_meip_i = 0; csr_mfip_i = 0;
    debug_req_i = 0; debug_single_step_i = 0; debug_ebreakm_i = 0; debug_ebreaku_i = 0;
    priv_mode_i = 2'b11;
    stall_lsu_i = 0; stall_multdiv_i = 0; stall_jump_i = 0; stall_branch_i = 0;

    // Reset state
    cyc(); cyc();
    chk("rst_instr_req", instr_req_o, 0);
    chk("rst_pc_set", pc_set_o, 0);
    chk("rst_busy", ctrl_busy_o, 0);
    chk("rst_debug_mode", debug_mode_o, 0);
    chk("rst_id_in_ready", id_in_ready_o, 0);

    // Boot sequence
    rst_i = 0; fetch_enable_i = 1;
    cyc();  // BOOT_SET
    chk("boot_pc_set", pc_set_o, 1);
    chk("boot_pc_mux", pc_mux_o, 0);
    chk("boot_instr_req", instr_req_o, 1);
    cyc();  // FIRST_FETCH
    chk("ff_instr_req", instr_req_o, 1);
    chk("ff_id_in_ready", id_in_ready_o, 1);
    cyc();  // DECODE
    chk("dec_busy", ctrl_busy_o, 1);

    // Stall holds ID; jump redirects in the same cycle
    stall_lsu_i = 1; #1;
    chk("stall_id_in_ready", id_in_ready_o, 0);
    chk("stall_valid_clear", instr_valid_clear_o, 0);
    stall_lsu_i = 0; jump_set_i = 1; #1;
    chk("jump_pc_set", pc_set_o, 1);
    chk("jump_pc_mux", pc_mux_o, 1);
    chk("jump_perf", perf_jump_o, 1);
    chk("jump_perf_tbranch", perf_tbranch_o, 0);
    jump_set_i = 0;

    // Illegal compressed instruction
    instr_valid_i = 1; illegal_insn_i = 1; instr_is_compressed_i = 1;
    instr_compressed_i = 16'h1234; instr_i = 32'hDEAD_BEEF;
    cyc();  // FLUSH
    chk("ill_cause", exc_cause_o, 6'h02);
    chk("ill_mtval", csr_mtval_o, 32'h0000_1234);
    chk("ill_pc_mux", pc_mux_o, 2);
    chk("ill_pc_set", pc_set_o, 1);
    chk("ill_exc_pc_mux", exc_pc_mux_o, 0);
    chk("ill_save_id", csr_save_id_o, 1);
    chk("ill_save_cause", csr_save_cause_o, 1);
    cyc();  // DECODE
    illegal_insn_i = 0; instr_is_compressed_i = 0;

    // mret from U-mode is illegal; mtval carries the full instruction word
    priv_mode_i = 2'b00; mret_insn_i = 1; instr_i = 32'h3020_0073;
    cyc();  // FLUSH
    chk("umret_cause", exc_cause_o, 6'h02);
    chk("umret_mtval", csr_mtval_o, 32'h3020_0073);
    chk("umret_no_restore", csr_restore_mret_id_o, 0);
    cyc();
    mret_insn_i = 0; priv_mode_i = 2'b11;

    // Load access fault
    load_err_i = 1; lsu_addr_last_i = 32'h0000_1FF4;
    cyc();  // FLUSH
    chk("lderr_cause", exc_cause_o, 6'h05);
    chk("lderr_mtval", csr_mtval_o, 32'h0000_1FF4);
    cyc();
    load_err_i = 0; instr_valid_i = 0;

    // Fast IRQ 1 beats external: 0x20 | (16+1)
    csr_mstatus_mie_i = 1; irq_pending_i = 1; csr_mfip_i = 15'h0006; csr_meip_i = 1;
    cyc();  // IRQ_TAKEN
    chk("irqf_cause", exc_cause_o, 6'h31);
    chk("irqf_exc_pc_mux", exc_pc_mux_o, 1);
    chk("irqf_save_if", csr_save_if_o, 1);
    chk("irqf_pc_mux", pc_mux_o, 2);
    csr_mfip_i = 0; csr_meip_i = 0; csr_msip_i = 1; csr_mtip_i = 1;
    cyc();  // DECODE
    cyc();  // IRQ_TAKEN, software beats timer
    chk("irqsw_cause", exc_cause_o, 6'h23);
    csr_mstatus_mie_i = 0; irq_pending_i = 0; csr_msip_i = 0; csr_mtip_i = 0;
    cyc();  // DECODE

    // NMI, masked while nmi_mode, re-armed by mret
    irq_nm_i = 1;
    cyc();  // IRQ_TAKEN
    chk("nmi_cause", exc_cause_o, 6'h3F);
    cyc();  // DECODE
    cyc();  // still DECODE
    chk("nmi_blocked", pc_set_o, 0);
    instr_valid_i = 1; mret_insn_i = 1;
    cyc();  // FLUSH
    chk("mret_pc_mux", pc_mux_o, 3);
    chk("mret_restore", csr_restore_mret_id_o, 1);
    cyc();  // DECODE
    instr_valid_i = 0; mret_insn_i = 0;
    cyc();  // IRQ_TAKEN again
    chk("nmi_rearm_cause", exc_cause_o, 6'h3F);
    irq_nm_i = 0;
    cyc();  // DECODE

    // Debug halt request and dret
    debug_req_i = 1;
    cyc();  // DBG_TAKEN_IF
    chk("dbg_cause", debug_cause_o, 3);
    chk("dbg_exc_pc_mux", exc_pc_mux_o, 2);
    chk("dbg_csr_save", debug_csr_save_o, 1);
    chk("dbg_save_if", csr_save_if_o, 1);
    debug_req_i = 0;
    cyc();  // DECODE
    chk("dbg_mode_set", debug_mode_o, 1);
    instr_valid_i = 1; dret_insn_i = 1;
    cyc();  // FLUSH
    chk("dret_pc_mux", pc_mux_o, 4);
    chk("dret_restore", csr_restore_dret_id_o, 1);
    cyc();  // DECODE
    instr_valid_i = 0; dret_insn_i = 0;
    chk("dret_mode_clr", debug_mode_o, 0);

    // M-mode ebreak into debug
    instr_valid_i = 1; ebrk_insn_i = 1; debug_ebreakm_i = 1;
    cyc();  // FLUSH
    chk("ebrk_flush_no_pcset", pc_set_o, 0);
    cyc();  // DBG_TAKEN_ID
    chk("ebrk_dbg_cause", debug_cause_o, 1);
    chk("ebrk_save_id", csr_save_id_o, 1);
    chk("ebrk_exc_pc_mux", exc_pc_mux_o, 2);
    ebrk_insn_i = 0; instr_valid_i = 0; debug_ebreakm_i = 0;
    cyc();  // DECODE
    chk("ebrk_mode_set", debug_mode_o, 1);
    instr_valid_i = 1; dret_insn_i = 1;
    cyc();  // FLUSH
    cyc();  // DECODE
    instr_valid_i = 0; dret_insn_i = 0;
    chk("ebrk_dret_clr", debug_mode_o, 0);

    // WFI sleep and wake
    instr_valid_i = 1; wfi_insn_i = 1;
    cyc();  // FLUSH
    cyc();  // WAIT_SLEEP
    instr_valid_i = 0; wfi_insn_i = 0;
    chk("wfi_wait_req", instr_req_o, 0);
    cyc();  // SLEEP
    chk("sleep_busy", ctrl_busy_o, 0);
    chk("sleep_req", instr_req_o, 0);
    cyc();  // SLEEP
    chk("sleep_busy_hold", ctrl_busy_o, 0);
    irq_pending_i = 1;
    cyc();  // FIRST_FETCH
    chk("wake_busy", ctrl_busy_o, 1);
    chk("wake_req", instr_req_o, 1);
    irq_pending_i = 0;
    cyc();  // DECODE

    // Reset while in debug mode
    debug_req_i = 1;
    cyc();  // DBG_TAKEN_IF
    debug_req_i = 0;
    cyc();  // DECODE
    chk("pre_rst_dbg", debug_mode_o, 1);
    rst_i = 1;
    cyc();  // RESET
    chk("midrst_dbg", debug_mode_o, 0);
    chk("midrst_req", instr_req_o, 0);
    chk("midrst_busy", ctrl_busy_o, 0);
    rst_i = 0; fetch_enable_i = 0;
    cyc();
    chk("hold_reset_pc_set", pc_set_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
